// File: rtl/ctrl_pkg.sv
// Shared state encoding, ALU operation codes and instruction-field constants
// for the multicycle ARM-subset controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    MULEX  = 4'd10,
    MULWB  = 4'd11,
    MULWBH = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_MOV   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_UMULL = 4'b1001;
  localparam logic [3:0] ALU_SMULL = 4'b1010;
  localparam logic [3:0] ALU_BAD   = 4'b1111;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] MCMD_MUL   = 4'b0000;
  localparam logic [3:0] MCMD_UMULL = 4'b0100;
  localparam logic [3:0] MCMD_SMULL = 4'b0110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [3:0] MUL_PATTERN = 4'b1001;

  function automatic logic [3:0] dp_alu_ctl(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      CMD_EOR: return ALU_EOR;
      CMD_MOV: return ALU_MOV;
      default: return ALU_BAD;
    endcase
  endfunction

  function automatic logic [3:0] mul_alu_ctl(input logic [3:0] cmd);
    case (cmd)
      MCMD_MUL:   return ALU_MUL;
      MCMD_UMULL: return ALU_UMULL;
      MCMD_SMULL: return ALU_SMULL;
      default:    return ALU_BAD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_cond_unit.sv
// Flags register and condition evaluation: CondEx from the current flags,
// CondExReg captured at the end of DECODE, flag writes gated by CondEx.
module ctrl_cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       latch_cond,
  output logic       cond_ex_reg
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
    if (latch_cond) cond_ex_d = cond_ex;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_reg = cond_ex_q;

endmodule

// File: rtl/multicycle_ctrl_mul.sv
// Multicycle ARM-subset controller: main FSM and decode, with an iterative
// multiply state of MUL_LAT cycles and two-word writeback for long multiplies.
module multicycle_ctrl_mul
  import ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 4,
  parameter int ALUCTL_W = 4,
  parameter int ST_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Instr,
  input  logic [3:0]          ALUFlags,
  output logic                PCWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          RegSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                AuxW,
  output logic                Mul,
  output logic                Busy,
  output logic [ST_W-1:0]     State
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       s_bit, is_mul, is_long, mul_last;
  logic [3:0] dp_ctl, mul_ctl;
  logic [1:0] dp_flag_w, flag_w;
  logic       cond_ex_reg;
  logic       pc_write, mem_write, reg_write, ir_write, aux_w;
  logic [3:0] alu_ctl;
  logic       unused_instr;

  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign is_mul   = (op == 2'b00) && !funct[5] && (Instr[7:4] == MUL_PATTERN);
  assign is_long  = (cmd == MCMD_UMULL) || (cmd == MCMD_SMULL);
  assign mul_last = (cnt_q == 4'(MUL_LAT - 1));
  assign dp_ctl   = dp_alu_ctl(cmd);
  assign mul_ctl  = mul_alu_ctl(cmd);
  assign unused_instr = ^{Instr[19:8], Instr[3:0]};

  always_comb begin
    dp_flag_w = 2'b00;
    if (s_bit) begin
      case (cmd)
        CMD_ADD, CMD_SUB, CMD_CMP:          dp_flag_w = 2'b11;
        CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV: dp_flag_w = 2'b10;
        default:                            dp_flag_w = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    ir_write  = 1'b0;
    aux_w     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_ctl   = ALU_ADD;
    Mul       = 1'b0;
    Busy      = 1'b0;
    flag_w    = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = is_mul ? MULEX : (funct[5] ? EXECI : EXECR);
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = cond_ex_reg;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        mem_write = cond_ex_reg;
        state_d   = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_ctl = dp_ctl;
        flag_w  = dp_flag_w;
        state_d = (cmd == CMD_CMP) ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_write = cond_ex_reg && (dp_ctl != ALU_BAD);
        state_d   = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_write  = cond_ex_reg;
        state_d   = FETCH;
      end
      MULEX: begin
        Mul     = 1'b1;
        Busy    = 1'b1;
        alu_ctl = mul_ctl;
        if (mul_last) begin
          flag_w  = (s_bit && mul_ctl != ALU_BAD) ? 2'b10 : 2'b00;
          cnt_d   = '0;
          state_d = MULWB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      MULWB: begin
        Mul       = 1'b1;
        alu_ctl   = mul_ctl;
        reg_write = cond_ex_reg && (mul_ctl != ALU_BAD);
        state_d   = is_long ? MULWBH : FETCH;
      end
      MULWBH: begin
        Mul       = 1'b1;
        aux_w     = 1'b1;
        alu_ctl   = mul_ctl;
        reg_write = cond_ex_reg && (mul_ctl != ALU_BAD);
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  ctrl_cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond        (Instr[31:28]),
    .alu_flags   (ALUFlags),
    .flag_w      (flag_w),
    .latch_cond  (state_q == DECODE),
    .cond_ex_reg (cond_ex_reg)
  );

  // Write enables are forced low for the whole time reset is asserted.
  assign PCWrite    = pc_write  && reset;
  assign MemWrite   = mem_write && reset;
  assign RegWrite   = reg_write && reset;
  assign IRWrite    = ir_write  && reset;
  assign AuxW       = aux_w     && reset;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign ImmSrc     = op;
  assign ALUControl = ALUCTL_W'(alu_ctl);
  assign State      = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_mul.sv
// Directed bench for multicycle_ctrl_mul: walks instruction sequences through
// the FSM and compares per-state outputs against hand-derived values.
module tb_multicycle_ctrl_mul;
  import ctrl_pkg::*;

  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_SUBS  = 32'hE2511001;
  localparam logic [31:0] I_CMP   = 32'hE3510000;
  localparam logic [31:0] I_BEQ   = 32'h0A000005;
  localparam logic [31:0] I_MUL   = 32'hE0000291;
  localparam logic [31:0] I_UMULL = 32'hE0832291;
  localparam logic [31:0] I_LDR   = 32'hE5912004;
  localparam logic [31:0] I_STR   = 32'hE5812004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, AuxW, Mul, Busy;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0]  ALUControl;
  logic [3:0]  State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl_mul #(.MUL_LAT(4), .ALUCTL_W(4), .ST_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .AuxW(AuxW), .Mul(Mul), .Busy(Busy), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Enters MULEX from DECODE, expects exactly 4 busy cycles, then writeback.
  task automatic run_mul(input string tag, input bit long_op, input logic [3:0] ctl);
    for (int i = 0; i < 4; i++) begin
      step();
      chk({tag, "_mulex_state"}, 32'(State), 32'(MULEX));
      chk({tag, "_busy"}, 32'(Busy), 1);
      chk({tag, "_mulex_ctl"}, 32'(ALUControl), 32'(ctl));
      chk({tag, "_mulex_regw"}, 32'(RegWrite), 0);
      chk({tag, "_mulex_auxw"}, 32'(AuxW), 0);
    end
    step();
    chk({tag, "_mulwb_state"}, 32'(State), 32'(MULWB));
    chk({tag, "_mulwb_busy"}, 32'(Busy), 0);
    chk({tag, "_mulwb_regw"}, 32'(RegWrite), 1);
    chk({tag, "_mulwb_auxw"}, 32'(AuxW), 0);
    chk({tag, "_mulwb_mul"}, 32'(Mul), 1);
    if (long_op) begin
      step();
      chk({tag, "_mulwbh_state"}, 32'(State), 32'(MULWBH));
      chk({tag, "_mulwbh_regw"}, 32'(RegWrite), 1);
      chk({tag, "_mulwbh_auxw"}, 32'(AuxW), 1);
    end
    step();
    chk({tag, "_ret_fetch"}, 32'(State), 32'(FETCH));
    chk({tag, "_ret_auxw"}, 32'(AuxW), 0);
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'b0000;
    step();
    step();
    chk("rst_state", 32'(State), 32'(FETCH));
    chk("rst_pcwrite", 32'(PCWrite), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);

    reset = 1'b1;
    Instr = I_ADD;
    #1;
    chk("fetch_pcwrite", 32'(PCWrite), 1);
    chk("fetch_irwrite", 32'(IRWrite), 1);
    chk("fetch_srcb", 32'(ALUSrcB), 2);
    chk("fetch_srca", 32'(ALUSrcA), 1);

    step();
    chk("add_decode", 32'(State), 32'(DECODE));
    chk("add_decode_regw", 32'(RegWrite), 0);
    step();
    chk("add_execr", 32'(State), 32'(EXECR));
    chk("add_execr_ctl", 32'(ALUControl), 32'(4'b0000));
    chk("add_execr_regw", 32'(RegWrite), 0);
    step();
    chk("add_aluwb", 32'(State), 32'(ALUWB));
    chk("add_aluwb_regw", 32'(RegWrite), 1);
    chk("add_aluwb_res", 32'(ResultSrc), 0);
    step();
    chk("add_fetch", 32'(State), 32'(FETCH));

    Instr    = I_SUBS;
    ALUFlags = 4'b0100;
    step();
    step();
    chk("subs_execi", 32'(State), 32'(EXECI));
    chk("subs_ctl", 32'(ALUControl), 32'(4'b0001));
    chk("subs_srcb", 32'(ALUSrcB), 1);
    step();
    chk("subs_aluwb", 32'(State), 32'(ALUWB));
    step();
    ALUFlags = 4'b0000;
    Instr    = I_BEQ;
    step();
    step();
    chk("beq_z1_state", 32'(State), 32'(BRANCH));
    chk("beq_z1_pcwrite", 32'(PCWrite), 1);
    step();

    Instr = I_CMP;
    step();
    step();
    chk("cmp_execi", 32'(State), 32'(EXECI));
    step();
    chk("cmp_skip_wb", 32'(State), 32'(FETCH));
    Instr = I_BEQ;
    step();
    step();
    chk("beq_z0_pcwrite", 32'(PCWrite), 0);
    step();

    Instr = I_MUL;
    step();
    run_mul("mul", 1'b0, 4'b1000);

    Instr = I_UMULL;
    step();
    run_mul("umull", 1'b1, 4'b1001);

    Instr = I_LDR;
    step();
    step();
    chk("ldr_memadr", 32'(State), 32'(MEMADR));
    chk("ldr_memadr_srcb", 32'(ALUSrcB), 1);
    step();
    chk("ldr_memrd", 32'(State), 32'(MEMRD));
    chk("ldr_memrd_adr", 32'(AdrSrc), 1);
    chk("ldr_memrd_regw", 32'(RegWrite), 0);
    step();
    chk("ldr_memwb", 32'(State), 32'(MEMWB));
    chk("ldr_memwb_res", 32'(ResultSrc), 1);
    chk("ldr_memwb_regw", 32'(RegWrite), 1);
    step();

    Instr = I_STR;
    step();
    chk("str_decode_memw", 32'(MemWrite), 0);
    step();
    chk("str_memadr_memw", 32'(MemWrite), 0);
    step();
    chk("str_memwr", 32'(State), 32'(MEMWR));
    chk("str_memwr_memw", 32'(MemWrite), 1);
    chk("str_memwr_adr", 32'(AdrSrc), 1);
    step();
    chk("str_fetch_memw", 32'(MemWrite), 0);

    // Set Z, then reset in the middle of a multiply; Z must be gone afterwards.
    Instr    = I_SUBS;
    ALUFlags = 4'b0100;
    step();
    step();
    step();
    step();
    ALUFlags = 4'b0000;
    Instr    = I_MUL;
    step();
    step();
    step();
    chk("rstmul_in_mulex", 32'(State), 32'(MULEX));
    reset = 1'b0;
    #1;
    chk("rstmul_regw", 32'(RegWrite), 0);
    chk("rstmul_auxw", 32'(AuxW), 0);
    step();
    chk("rstmul_state", 32'(State), 32'(FETCH));
    chk("rstmul_pcwrite", 32'(PCWrite), 0);
    chk("rstmul_irwrite", 32'(IRWrite), 0);
    chk("rstmul_busy", 32'(Busy), 0);
    reset = 1'b1;
    Instr = I_BEQ;
    step();
    step();
    chk("rstmul_beq_state", 32'(State), 32'(BRANCH));
    chk("rstmul_flags_clr", 32'(PCWrite), 0);
    step();
    Instr = I_MUL;
    step();
    run_mul("postrst_mul", 1'b0, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_mul.md
Name: multicycle_ctrl_mul

Overview:
- Next-generation multicycle ARM-subset controller: main FSM, instruction decode and registered condition logic in one block.
- Adds an iterative multiply path with parametrised latency and two-word writeback for long multiplies (low word, then high word on AuxW).
- Sits between the instruction register and the multicycle datapath; all datapath selects and write enables come from here.

Parameters:
- MUL_LAT, 4, cycles spent in MULEX (1..15); the datapath multiplier is valid after MUL_LAT cycles.
- ALUCTL_W, 4, ALUControl width.
- ST_W, 4, state encoding width.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-low
- Instr  in  32  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- PCWrite  out  1  PC enable
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- RegSrc  out  2  register-address selects
- ALUSrcA  out  2  00 = RD1, 01 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = const 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  Instr[27:26]
- ALUControl  out  ALUCTL_W  operation code
- AuxW  out  1  write the high word of a long multiply
- Mul  out  1  selects the multiplier result path
- Busy  out  1  high while in MULEX
- State  out  ST_W  current state, for debug

Behaviour:
- Reset:
  - reset==0 at a clk edge forces state=FETCH, Flags=0, CondExReg=0, mul counter=0.
  - This applies mid-instruction too, including during MULEX.
  - While reset==0, PCWrite, MemWrite, RegWrite, IRWrite and AuxW are 0.
- Outputs are a combinational function of the state. Per-state values not listed below are 0.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR
  - Op=10 -> BRANCH
  - Op=00 with mul pattern (Funct[5]=0, Instr[7:4]=1001) -> MULEX
  - Op=00, Funct[5]=0 -> EXECR
  - Op=00, Funct[5]=1 -> EXECI
  - Op=11 -> FETCH (NOP)
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExReg -> FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExReg -> FETCH.
- EXECR / EXECI:
  - ALUSrcA=00, ALUSrcB=00 (EXECR) or 01 (EXECI), ALUControl from cmd.
  - Next state ALUWB; CMP (cmd 1010) goes to FETCH instead.
- ALUWB: ResultSrc=00, RegWrite=CondExReg -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExReg -> FETCH.
- MULEX:
  - Mul=1, Busy=1; the counter increments each cycle.
  - Leave when count==MUL_LAT-1 (exactly MUL_LAT cycles) -> MULWB.
  - The counter clears on exit.
- MULWB: Mul=1, RegWrite=CondExReg. If long (Funct[4:1]=0100 UMULL or 0110 SMULL) -> MULWBH, else FETCH.
- MULWBH: Mul=1, AuxW=1, RegWrite=CondExReg -> FETCH.
- ALUControl codes:
  - ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101, MUL 1000, UMULL 1001, SMULL 1010.
  - An unsupported cmd gives 1111 and suppresses RegWrite.
- Condition logic:
  - Standard ARM cond decode on the Flags register: EQ..LE, AL=1110; 1111 is never.
  - CondExReg latches CondEx at the end of DECODE.
  - FlagW = S ? (ADD/SUB/CMP: 11; logic/MUL: 10) : 00.
  - Flags[3:2] update on FlagW[1]&CondEx; Flags[1:0] update on FlagW[0]&CondEx.
  - The update happens at the end of EXECR, EXECI or the last MULEX cycle, using ALUFlags.
- Instr is stable from DECODE until return to FETCH; the block does not re-sample it.

Decomposition:
- ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, MULEX, MULWB, MULWBH
  - ALUControl codes, cond codes, mul-pattern constant
- One sub-module, ctrl_cond_unit: Flags register, CondEx, CondExReg, FlagW gating.

Test Plan:
- ADD R1,R2,R3 (E0821003), AL: FETCH→DECODE→EXECR→ALUWB→FETCH. RegWrite=1 only in ALUWB, ALUControl=0000 in EXECR.
- SUBS with ALUFlags=0100, then BEQ: Z latched. Branch PCWrite=1 in BRANCH; with Z=0, PCWrite=0 in BRANCH.
- MUL (E0000291), MUL_LAT=4: Busy high for exactly 4 cycles, then MULWB RegWrite=1 → FETCH; AuxW never asserted.
- UMULL (E0832291): MULEX 4 cycles → MULWB RegWrite=1, AuxW=0 → MULWBH RegWrite=1, AuxW=1.
- LDR then STR: MEMRD AdrSrc=1, MEMWB ResultSrc=01 RegWrite=1. MEMWR MemWrite=1, and only that cycle.
- reset=0 during the 2nd MULEX cycle: next state FETCH, Flags=0, counter=0, all write enables 0 while reset is low.
